// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: ALU opcode fields and operand forward-select encoding.
package id_ex_stage_pkg;

    // aluc[2:0] selects the result; aluc[3] picks the alternate form; aluc[4] marks arithmetic shift.
    localparam logic [2:0] ALUC_SEL_ADD = 3'd0;
    localparam logic [2:0] ALUC_SEL_AND = 3'd1;
    localparam logic [2:0] ALUC_SEL_XOR = 3'd2;
    localparam logic [2:0] ALUC_SEL_SLL = 3'd3;
    localparam logic [2:0] ALUC_SEL_SRL = 3'd4;
    localparam logic [2:0] ALUC_SEL_SLT = 3'd5;
    localparam logic [2:0] ALUC_SEL_LUI = 3'd6;
    localparam int unsigned ALUC_BIT_ALT   = 3;
    localparam int unsigned ALUC_BIT_ARITH = 4;

    localparam logic [5:0] ALUC_ADD = 6'b00_0000;
    localparam logic [5:0] ALUC_SUB = 6'b00_1000;
    localparam logic [5:0] ALUC_AND = 6'b00_0001;
    localparam logic [5:0] ALUC_OR  = 6'b00_1001;
    localparam logic [5:0] ALUC_SRA = 6'b01_1100;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EXM = 2'b01,
        FWD_MWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forward-select for one source operand; EX/MEM beats MEM/WB, loads and x0 never forward.
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              exm_wreg_i,
    input  logic              exm_m2reg_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic              mwb_wreg_i,
    output fwd_sel_e          sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (exm_wreg_i && !exm_m2reg_i && (exm_rd_i != '0) && (exm_rd_i == rs_i)) begin
            sel_o = FWD_EXM;
        end else if (mwb_wreg_i && (mwb_rd_i != '0) && (mwb_rd_i == rs_i)) begin
            sel_o = FWD_MWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, load-use bubble insertion, flush and hold.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     REG_AW   = 5,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [5:0]        id_aluc,
    input  logic              id_asel,
    input  logic              id_bsel,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              flush,
    input  logic              hold,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_wreg,
    input  logic              exm_m2reg,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_wreg,
    input  logic [XLEN-1:0]   mwb_data,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [5:0]        alu_aluc,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wreg,
    output logic              ex_m2reg,
    output logic              ex_wmem,
    output logic [XLEN-1:0]   ex_pc
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [5:0]        aluc_q, aluc_d;
    logic              asel_q, asel_d, bsel_q, bsel_d;
    logic              wreg_q, wreg_d, m2reg_q, m2reg_d, wmem_q, wmem_d;
    logic              luse;
    fwd_sel_e          sel_rs1, sel_rs2;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

    assign luse = valid_q && m2reg_q && (rd_q != '0) && id_valid &&
                  ((id_use_rs1 && (id_rs1 == rd_q)) || (id_use_rs2 && (id_rs2 == rd_q)));
    // rst_n gating keeps decode free-running while the stage is held in reset.
    assign stall_id = (luse || hold) && !flush && rst_n;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        aluc_d     = aluc_q;
        asel_d     = asel_q;
        bsel_d     = bsel_q;
        wreg_d     = wreg_q;
        m2reg_d    = m2reg_q;
        wmem_d     = wmem_q;
        if (flush || (!hold && luse)) begin
            valid_d = 1'b0;
            wreg_d  = 1'b0;
            m2reg_d = 1'b0;
            wmem_d  = 1'b0;
        end else if (!hold) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            aluc_d     = id_aluc;
            asel_d     = id_asel;
            bsel_d     = id_bsel;
            wreg_d     = id_wreg  && id_valid;
            m2reg_d    = id_m2reg && id_valid;
            wmem_d     = id_wmem  && id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            aluc_q     <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            wreg_q     <= 1'b0;
            m2reg_q    <= 1'b0;
            wmem_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            aluc_q     <= aluc_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            wreg_q     <= wreg_d;
            m2reg_q    <= m2reg_d;
            wmem_q     <= wmem_d;
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_i(rs1_q), .exm_rd_i(exm_rd), .exm_wreg_i(exm_wreg), .exm_m2reg_i(exm_m2reg),
        .mwb_rd_i(mwb_rd), .mwb_wreg_i(mwb_wreg), .sel_o(sel_rs1)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_i(rs2_q), .exm_rd_i(exm_rd), .exm_wreg_i(exm_wreg), .exm_m2reg_i(exm_m2reg),
        .mwb_rd_i(mwb_rd), .mwb_wreg_i(mwb_wreg), .sel_o(sel_rs2)
    );

    always_comb begin
        unique case (sel_rs1)
            FWD_EXM: fwd_rs1 = exm_result;
            FWD_MWB: fwd_rs1 = mwb_data;
            default: fwd_rs1 = rs1_data_q;
        endcase
        unique case (sel_rs2)
            FWD_EXM: fwd_rs2 = exm_result;
            FWD_MWB: fwd_rs2 = mwb_data;
            default: fwd_rs2 = rs2_data_q;
        endcase
    end

    assign alu_a         = asel_q ? pc_q : fwd_rs1;
    assign alu_b         = bsel_q ? imm_q : fwd_rs2;
    assign alu_aluc      = aluc_q;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_pc         = pc_q;
    assign ex_valid      = valid_q;
    assign ex_wreg       = wreg_q  && valid_q;
    assign ex_m2reg      = m2reg_q && valid_q;
    assign ex_wmem       = wmem_q  && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle behavioural model plus hand-computed spot checks.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [31:0] RPC = 32'hCAFE_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 0, id_asel = 0, id_bsel = 0, id_wreg = 0, id_m2reg = 0, id_wmem = 0;
    logic        id_use_rs1 = 0, id_use_rs2 = 0, flush = 0, hold = 0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [5:0]  id_aluc = '0;
    logic [4:0]  exm_rd = '0, mwb_rd = '0;
    logic        exm_wreg = 0, exm_m2reg = 0, mwb_wreg = 0;
    logic [31:0] exm_result = '0, mwb_data = '0;
    logic        stall_id, ex_valid, ex_wreg, ex_m2reg, ex_wmem;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [5:0]  alu_aluc;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluc(id_aluc),
        .id_asel(id_asel), .id_bsel(id_bsel), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_wmem(id_wmem), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .flush(flush), .hold(hold), .exm_rd(exm_rd), .exm_wreg(exm_wreg),
        .exm_m2reg(exm_m2reg), .exm_result(exm_result), .mwb_rd(mwb_rd),
        .mwb_wreg(mwb_wreg), .mwb_data(mwb_data), .stall_id(stall_id),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
        .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: what instruction sits in EX, as a plain record.
    typedef struct {
        bit          v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  aluc;
        bit          asel, bsel, wreg, m2reg, wmem;
    } ex_t;
    ex_t m;

    function automatic bit m_luse();
        if (!(m.v && m.m2reg && m.rd != 0 && id_valid)) return 0;
        return (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return rf;
        if (exm_wreg && !exm_m2reg && exm_rd == rs) return exm_result;
        if (mwb_wreg && mwb_rd == rs) return mwb_data;
        return rf;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '{default: '0};
            m.pc = RPC;
        end else if (flush) begin
            m.v = 0; m.wreg = 0; m.m2reg = 0; m.wmem = 0;
        end else if (hold) begin
            m = m;
        end else if (m_luse()) begin
            m.v = 0; m.wreg = 0; m.m2reg = 0; m.wmem = 0;
        end else begin
            m.v = id_valid; m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
            m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.aluc = id_aluc; m.asel = id_asel; m.bsel = id_bsel;
            m.wreg = id_wreg && id_valid; m.m2reg = id_m2reg && id_valid;
            m.wmem = id_wmem && id_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_stall", {31'b0, stall_id}, {31'b0, (m_luse() || hold) && !flush});
            chk("m_valid", {31'b0, ex_valid}, {31'b0, m.v});
            chk("m_ctrl", {29'b0, ex_wreg, ex_m2reg, ex_wmem}, {29'b0, m.wreg, m.m2reg, m.wmem});
            if (m.v) begin
                chk("m_alu_a", alu_a, m.asel ? m.pc : operand(m.rs1, m.d1));
                chk("m_alu_b", alu_b, m.bsel ? m.imm : operand(m.rs2, m.d2));
                chk("m_store", ex_store_data, operand(m.rs2, m.d2));
                chk("m_aluc", {26'b0, alu_aluc}, {26'b0, m.aluc});
                chk("m_rd", {27'b0, ex_rd}, {27'b0, m.rd});
                chk("m_pc", ex_pc, m.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rd, input logic bsel, input logic wreg,
                          input logic m2reg, input logic u1, input logic u2);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
        id_rs2_data = d2; id_imm = imm; id_rd = rd; id_bsel = bsel; id_asel = 0;
        id_wreg = wreg; id_m2reg = m2reg; id_wmem = 0; id_use_rs1 = u1; id_use_rs2 = u2;
        id_aluc = ALUC_ADD;
    endtask

    task automatic no_fwd();
        exm_wreg = 0; exm_m2reg = 0; exm_rd = 0; mwb_wreg = 0; mwb_rd = 0;
    endtask

    initial begin
        tick();
        chk("reset_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset_pc", ex_pc, RPC);
        chk("reset_stall", {31'b0, stall_id}, 32'd0);
        rst_n = 1;

        // Independent instruction: a = 5, b = imm 7.
        set_id(32'h100, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd4, 1, 1, 0, 1, 0);
        tick();
        chk("ind_alu_a", alu_a, 32'd5);
        chk("ind_alu_b", alu_b, 32'd7);
        chk("ind_valid", {31'b0, ex_valid}, 32'd1);

        // Double forwarding on rs1 = 3.
        set_id(32'h104, 5'd3, 32'h99, 5'd2, 32'd0, 32'd0, 5'd6, 0, 1, 0, 1, 1);
        tick();
        exm_rd = 3; exm_wreg = 1; exm_result = 32'h10;
        mwb_rd = 3; mwb_wreg = 1; mwb_data = 32'h20;
        #1 chk("fwd_exm", alu_a, 32'h10);
        exm_wreg = 0;
        #1 chk("fwd_mwb", alu_a, 32'h20);
        set_id(32'h108, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd7, 0, 1, 0, 1, 1);
        tick();
        exm_rd = 0; exm_wreg = 1; exm_result = 32'hFFFF_FFFF; mwb_wreg = 0;
        #1 chk("fwd_x0_a", alu_a, 32'd0);
        chk("fwd_x0_b", alu_b, 32'd0);

        // Load-use: load x5, then consumer reading rs2 = 5.
        no_fwd();
        set_id(32'h10C, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 1, 1, 1, 1, 0);
        tick();
        set_id(32'h110, 5'd6, 32'd1, 5'd5, 32'hDEAD, 32'd0, 5'd7, 0, 1, 0, 1, 1);
        #1 chk("lu_stall", {31'b0, stall_id}, 32'd1);
        tick();
        exm_rd = 5; exm_wreg = 1; exm_m2reg = 1;
        chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_wreg", {31'b0, ex_wreg}, 32'd0);
        chk("lu_unstall", {31'b0, stall_id}, 32'd0);
        tick();
        no_fwd();
        mwb_rd = 5; mwb_wreg = 1; mwb_data = 32'h1234;
        #1 chk("lu_enter", {31'b0, ex_valid}, 32'd1);
        chk("lu_alu_a", alu_a, 32'd1);
        chk("lu_alu_b", alu_b, 32'h1234);
        chk("lu_store", ex_store_data, 32'h1234);

        // Flush during load-use.
        no_fwd();
        set_id(32'h120, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 1, 1, 1, 1, 0);
        tick();
        set_id(32'h124, 5'd5, 32'd0, 5'd0, 32'd0, 32'd0, 5'd8, 0, 1, 0, 1, 0);
        flush = 1;
        #1 chk("fl_stall", {31'b0, stall_id}, 32'd0);
        tick();
        flush = 0;
        chk("fl_valid", {31'b0, ex_valid}, 32'd0);
        chk("fl_wreg", {31'b0, ex_wreg}, 32'd0);
        id_valid = 0;
        tick();

        // Hold with a load in EX and a dependent instruction in decode.
        set_id(32'h200, 5'd1, 32'h11, 5'd2, 32'h33, 32'h22, 5'd9, 1, 1, 1, 1, 0);
        tick();
        set_id(32'h300, 5'd9, 32'h44, 5'd0, 32'd0, 32'h55, 5'd10, 1, 1, 0, 1, 0);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", {31'b0, stall_id}, 32'd1);
            tick();
            chk("hold_pc", ex_pc, 32'h200);
            chk("hold_alu_b", alu_b, 32'h22);
            chk("hold_m2reg", {31'b0, ex_m2reg}, 32'd1);
        end
        hold = 0;
        #1 chk("hold_luse_stall", {31'b0, stall_id}, 32'd1);
        tick();
        chk("hold_bubble", {31'b0, ex_valid}, 32'd0);
        tick();
        chk("hold_resume_pc", ex_pc, 32'h300);
        chk("hold_resume_b", alu_b, 32'h55);

        // Asynchronous reset mid-cycle while stalling.
        hold = 1;
        #2 rst_n = 0;
        #1 chk("ar_valid", {31'b0, ex_valid}, 32'd0);
        chk("ar_wreg", {31'b0, ex_wreg}, 32'd0);
        chk("ar_pc", ex_pc, RPC);
        chk("ar_stall", {31'b0, stall_id}, 32'd0);
        hold = 0; id_valid = 0;
        tick();
        rst_n = 1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
